// File: rtl/io_mmio.sv
// Memory-mapped IO block: UART TX holding register, RX FIFO, and cycle/instruction counters.
// Loads return data one cycle later on io_dout. A load of RX data pops the FIFO head.
module io_mmio #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic        io_re,
  input  logic        io_we,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wbe,
  input  logic        inst_retired,
  output logic [31:0] io_dout,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready
);
  localparam int PW = $clog2(RX_DEPTH);
  localparam logic [PW:0] FULL_CNT = RX_DEPTH[PW:0];

  logic          sel, ld, st;
  logic [7:0]    off;
  logic          tx_pending, tx_hs, tx_wr;
  logic [7:0]    tx_data;
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   rx_count;
  logic          rx_empty, rx_full, rx_push, rx_pop;
  logic [31:0]   cyc_cnt, inst_cnt;
  logic          cnt_clr;
  logic [31:0]   rd_data;

  assign sel = (io_addr[31:28] == 4'h8);
  assign off = io_addr[7:0];
  assign ld  = io_re & sel;
  assign st  = io_we & sel & (io_wbe != 4'b0);

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_push  = uart_rx_data_out_valid & ~rx_full;
  assign rx_pop   = ld & (off == 8'h04) & ~rx_empty;

  // A new byte may land in the same cycle the previous one is handed off.
  assign tx_hs   = tx_pending & uart_tx_data_in_ready;
  assign tx_wr   = st & (off == 8'h08) & io_wbe[0];
  assign cnt_clr = st & (off == 8'h18);

  assign uart_tx_data_in        = tx_data;
  assign uart_tx_data_in_valid  = tx_pending;
  assign uart_rx_data_out_ready = ~rx_full;

  wire unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (off)
        8'h00: rd_data = {30'b0, ~rx_empty, ~tx_pending};
        8'h04: if (!rx_empty) rd_data = {24'b0, rx_mem[rd_ptr]};
        8'h10: rd_data = cyc_cnt;
        8'h14: rd_data = inst_cnt;
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[wr_ptr] <= uart_rx_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_dout    <= '0;
      tx_pending <= 1'b0;
      tx_data    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rx_count   <= '0;
      cyc_cnt    <= '0;
      inst_cnt   <= '0;
    end else begin
      if (io_re) io_dout <= rd_data;

      if (tx_wr && (!tx_pending || tx_hs)) begin
        tx_data    <= io_wdata[7:0];
        tx_pending <= 1'b1;
      end else if (tx_hs) begin
        tx_pending <= 1'b0;
      end

      if (rx_push) wr_ptr <= wr_ptr + 1'b1;
      if (rx_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase

      if (cnt_clr) begin
        cyc_cnt  <= '0;
        inst_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
        if (inst_retired) inst_cnt <= inst_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_io_mmio.sv
// Bench for io_mmio: queue-based reference model, load scoreboard, directed scenarios plus random traffic.
module tb_io_mmio;
  localparam int D = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] io_addr = '0, io_wdata = '0, io_dout;
  logic        io_re = 1'b0, io_we = 1'b0, inst_retired = 1'b0;
  logic [3:0]  io_wbe = '0;
  logic [7:0]  tx_d, rx_d = '0;
  logic        tx_v, tx_rdy = 1'b0, rx_v = 1'b0, rx_rdy;

  always #5 clk = ~clk;

  io_mmio #(.RX_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_re(io_re), .io_we(io_we),
    .io_wdata(io_wdata), .io_wbe(io_wbe), .inst_retired(inst_retired), .io_dout(io_dout),
    .uart_tx_data_in(tx_d), .uart_tx_data_in_valid(tx_v), .uart_tx_data_in_ready(tx_rdy),
    .uart_rx_data_out(rx_d), .uart_rx_data_out_valid(rx_v), .uart_rx_data_out_ready(rx_rdy)
  );

  int n_chk = 0, n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model state
  logic [7:0]  rxq[$];
  logic [31:0] exp_q[$];
  bit          m_pend, started;
  logic [7:0]  m_tx, m_byte;
  logic [31:0] m_cyc, m_inst, m_dout, m_e;
  logic        m_sel, m_full, m_hs, m_st;
  logic [7:0]  m_off;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      rxq.delete(); exp_q.delete();
      m_pend = 0; m_tx = '0; m_cyc = '0; m_inst = '0; m_dout = '0;
    end else begin
      m_sel  = (io_addr[31:28] == 4'h8);
      m_off  = io_addr[7:0];
      m_full = (rxq.size() == D);
      m_hs   = m_pend && tx_rdy;
      m_st   = io_we && m_sel && (io_wbe != 0);
      if (io_re) begin
        m_e = '0;
        if (m_sel) begin
          case (m_off)
            8'h00: m_e = {30'b0, rxq.size() != 0, !m_pend};
            8'h04: if (rxq.size() != 0) begin m_byte = rxq.pop_front(); m_e = {24'b0, m_byte}; end
            8'h10: m_e = m_cyc;
            8'h14: m_e = m_inst;
            default: m_e = '0;
          endcase
        end
        exp_q.push_back(m_e);
        m_dout = m_e;
      end
      if (m_st && m_off == 8'h08 && io_wbe[0] && (!m_pend || m_hs)) begin
        m_tx = io_wdata[7:0]; m_pend = 1;
      end else if (m_hs) m_pend = 0;
      if (rx_v && !m_full) rxq.push_back(rx_d);
      if (m_st && m_off == 8'h18) begin
        m_cyc = '0; m_inst = '0;
      end else begin
        m_cyc = m_cyc + 1;
        if (inst_retired) m_inst = m_inst + 1;
      end
    end
  end

  // Monitor: load results come off the scoreboard queue; otherwise io_dout must hold.
  always @(negedge clk) begin
    if (started) begin
      chk("tx_valid", tx_v, m_pend);
      if (m_pend) chk("tx_data", tx_d, m_tx);
      chk("rx_ready", rx_rdy, rxq.size() < D);
      if (exp_q.size() != 0) chk("load_data", io_dout, exp_q.pop_front());
      else chk("dout_hold", io_dout, m_dout);
    end
  end

  task automatic op(input bit re, input bit we, input logic [31:0] a,
                    input logic [31:0] wd, input logic [3:0] be);
    io_re = re; io_we = we; io_addr = a; io_wdata = wd; io_wbe = be;
    @(negedge clk);
    io_re = 0; io_we = 0; io_wbe = '0;
  endtask

  logic [7:0]  rxb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0]  offs [11] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h08, 8'h08,
                             8'h10, 8'h14, 8'h18, 8'h0C, 8'h20};
  logic [31:0] ra;

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;

    // TX held while the transmitter is busy, then released
    op(0, 1, 32'h8000_0008, 32'h0000_0041, 4'h1);
    repeat (3) begin
      chk("tx_busy_valid", tx_v, 1);
      chk("tx_busy_data", tx_d, 8'h41);
      op(1, 0, 32'h8000_0000, 0, 0);
      chk("tx_busy_ctrl", io_dout, 0);
    end
    tx_rdy = 1; @(negedge clk); tx_rdy = 0;
    chk("tx_done_valid", tx_v, 0);
    op(1, 0, 32'h8000_0000, 0, 0);
    chk("tx_done_ctrl", io_dout, 1);

    // RX fill to full, overflow byte dropped, drain in order
    for (int i = 0; i < 4; i++) begin rx_v = 1; rx_d = rxb[i]; @(negedge clk); end
    rx_d = 8'h55; @(negedge clk); rx_v = 0;
    chk("rx_full_ready", rx_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      op(1, 0, 32'h8000_0004, 0, 0);
      chk("rx_drain", io_dout, {24'b0, rxb[i]});
    end
    op(1, 0, 32'h8000_0004, 0, 0);
    chk("rx_empty_load", io_dout, 0);
    op(1, 0, 32'h8000_0000, 0, 0);
    chk("rx_empty_ctrl", io_dout, 1);

    // Counters
    rst = 1; @(negedge clk); rst = 0;
    repeat (10) @(negedge clk);
    op(1, 0, 32'h8000_0010, 0, 0);
    chk("cyc_after_idle", io_dout, 10);
    inst_retired = 1; repeat (5) @(negedge clk); inst_retired = 0;
    op(1, 0, 32'h8000_0014, 0, 0);
    chk("inst_count", io_dout, 5);
    op(0, 1, 32'h8000_0018, 0, 4'hF);
    op(1, 0, 32'h8000_0010, 0, 0);
    chk("cyc_cleared", io_dout, 0);
    op(1, 0, 32'h8000_0010, 0, 0);
    chk("cyc_resumed", io_dout, 1);

    // Unmapped load, then reset in the middle of a pending TX
    op(1, 0, 32'h8000_0020, 0, 0);
    chk("unmapped_load", io_dout, 0);
    op(0, 1, 32'h8000_0008, 32'h0000_005A, 4'h1);
    op(1, 0, 32'h8000_0014, 0, 0);
    op(1, 0, 32'h8000_0010, 0, 0);
    chk("tx_pending_pre_rst", tx_v, 1);
    rst = 1; @(negedge clk); rst = 0;
    chk("rst_tx_valid", tx_v, 0);
    chk("rst_dout", io_dout, 0);
    chk("rst_rx_ready", rx_rdy, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      ra = {(($urandom % 8) == 0) ? 4'($urandom_range(0, 7)) : 4'h8, 20'($urandom),
            offs[$urandom % 11]};
      io_addr      = ra;
      io_re        = ($urandom % 3) != 0;
      io_we        = ($urandom % 3) == 0;
      io_wdata     = $urandom;
      io_wbe       = (($urandom % 8) == 0) ? 4'h0 : 4'($urandom);
      tx_rdy       = ($urandom % 3) != 0;
      rx_v         = ($urandom % 4) == 0;
      rx_d         = 8'($urandom);
      inst_retired = $urandom % 2;
      rst          = ($urandom % 500) == 0;
      @(negedge clk);
    end
    io_re = 0; io_we = 0; rx_v = 0; rst = 0; inst_retired = 0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/io_mmio.md
IO_MMIO -- requirements
Module: io_mmio

Interface
REQ-001 The block SHALL have one parameter: RX_DEPTH, default 4, the RX FIFO depth in entries (a power of 2, at least 2).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Reset, synchronous, active-high.
- io_addr  in  32  Byte address of the load or store issued by the memory stage.
- io_re  in  1  Load strobe.
- io_we  in  1  Store strobe.
- io_wdata  in  32  Store data.
- io_wbe  in  4  Store byte enables.
- inst_retired  in  1  One-cycle pulse from writeback for each retired instruction.
- io_dout  out  32  Load data, registered.
- uart_tx_data_in  out  8  Byte to the UART transmitter.
- uart_tx_data_in_valid  out  1  Transmit byte valid.
- uart_tx_data_in_ready  in  1  Transmitter ready.
- uart_rx_data_out  in  8  Byte from the UART receiver.
- uart_rx_data_out_valid  in  1  Receive byte valid.
- uart_rx_data_out_ready  out  1  Block can accept a receive byte.

Function
REQ-003 The block SHALL decode an access only when io_addr[31:28]==4'h8, using io_addr[7:0] as the register offset.
REQ-004 The register map SHALL be:
- 0x00: control, read-only, {30'b0, rx_valid, tx_ready}.
- 0x04: RX data, read-only.
- 0x08: TX data, write-only.
- 0x10: cycle counter, read-only.
- 0x14: instruction counter, read-only.
- 0x18: counter reset, write-only.
REQ-005 Load latency SHALL be 1 cycle: io_dout is updated at the edge that ends a cycle with io_re=1, and holds its value otherwise.
REQ-006 A load from an unmapped or write-only offset, or with io_addr[31:28]!=8, SHALL return 32'h0.
REQ-007 tx_ready SHALL equal !tx_pending, and rx_valid SHALL equal FIFO not empty.
REQ-008 A store to 0x08 with io_wbe[0]=1 while tx_pending=0 SHALL load io_wdata[7:0] into the TX holding register and set tx_pending=1.
REQ-009 A store to 0x08 while tx_pending=1 SHALL be dropped, except in the cycle the handshake completes, when the new byte is accepted and tx_pending stays 1.
REQ-010 uart_tx_data_in_valid SHALL equal tx_pending, and tx_pending SHALL clear on valid&ready unless REQ-009 applies.
REQ-011 The RX FIFO SHALL push uart_rx_data_out on uart_rx_data_out_valid&uart_rx_data_out_ready, where uart_rx_data_out_ready = !full.
REQ-012 A load from 0x04 with the FIFO non-empty SHALL return {24'b0, head} and pop the head; with the FIFO empty it SHALL return 0 and not pop.
REQ-013 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged; a pop on a full FIFO SHALL raise ready in the next cycle.
REQ-014 FIFO pointers SHALL wrap modulo RX_DEPTH, and the count SHALL range over 0..RX_DEPTH.
REQ-015 The cycle counter SHALL increment by 1 every cycle, wrapping at 2^32.
REQ-016 The instruction counter SHALL increment on inst_retired, wrapping at 2^32.
REQ-017 A load of a counter SHALL return the value held before that cycle's increment.
REQ-018 Any store to 0x18 SHALL set both counters to 0 at that edge, overriding the increment, with counting resuming the following cycle.
REQ-019 When io_re and io_we are asserted in the same cycle, the store SHALL take effect and the load SHALL return pre-store state.
REQ-020 Stores to unmapped offsets or with io_wbe=0 SHALL be ignored.

Reset
REQ-021 With rst=1 at an edge, the block SHALL clear io_dout, tx_pending, the TX holding register, the FIFO pointers and count, and both counters to 0.
REQ-022 During reset, uart_tx_data_in_valid SHALL be 0 and uart_rx_data_out_ready SHALL be 1 from the first post-reset cycle.
REQ-023 Reset SHALL discard any in-flight TX byte or buffered RX data.

Verification
REQ-024 TX: store 0x41 to 0x80000008 with ready=0 for 3 cycles -> valid=1 and data=0x41, control reads 0x0; set ready=1 -> valid drops the next cycle and control reads 0x1.
REQ-025 RX: push 0x11,0x22,0x33,0x44 -> ready=0 and a 5th byte is not taken; four loads of 0x80000004 -> 0x11,0x22,0x33,0x44; a fifth load -> 0; control bit1 = 0.
REQ-026 Counters: after reset, idle 10 cycles then load 0x80000010 -> 10; pulse inst_retired 5 times -> 0x80000014 reads 5.
REQ-027 Counter reset: store to 0x80000018, then load 0x80000010 the next cycle -> 0.
REQ-028 Unmapped and reset: load 0x80000020 -> 0; assert rst mid-TX with valid=1 -> valid=0 the next cycle and io_dout=0.
